// File: rtl/vend_countdown_if.sv
// Signal bundle between the vending FSM (master) and the transaction countdown timer (slave).
// The 1 Hz square wave c_e from the divider also travels in this bundle.
interface vend_countdown_if #(
  parameter int WIDTH = 8
);
  logic             c_e;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             cancel;
  logic [WIDTH-1:0] secs_left;
  logic             busy;
  logic             expired;
  logic             tick;

  modport master (
    output c_e, start, load_val, pause, cancel,
    input  secs_left, busy, expired, tick
  );

  modport slave (
    input  c_e, start, load_val, pause, cancel,
    output secs_left, busy, expired, tick
  );
endinterface

// File: rtl/vend_countdown.sv
// Seconds countdown for the vending transaction timeout: turns each c_e rising edge into a tick,
// counts a loaded value down to zero and pulses expired for one cycle; supports restart, pause and cancel.
module vend_countdown #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  vend_countdown_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] secs_q;
  logic [WIDTH-1:0] secs_next;
  logic             c_e_q;
  logic             tick_q;
  logic             rise;

  assign rise = bus.c_e & ~c_e_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      secs_q <= '0;
      c_e_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_next;
      secs_q <= secs_next;
      c_e_q  <= bus.c_e;
      tick_q <= rise;
    end
  end

  // Priority: cancel over start over pause over rise.
  always_comb begin
    // NOTE: hold-current defaults first, so no path through this block can infer a latch.
    state_next = state;
    secs_next  = secs_q;
    if (bus.cancel) begin
      state_next = IDLE;
      secs_next  = '0;
    end else if (bus.start) begin
      secs_next  = bus.load_val;
      state_next = (bus.load_val == '0) ? DONE : RUN;
    end else begin
      unique case (state)
        IDLE: begin
          state_next = IDLE;
        end
        RUN: begin
          if (bus.pause) begin
            state_next = PAUSED;
          end else if (rise) begin
            // A count of 1 goes straight to DONE, so the decrement can never wrap.
            if (secs_q == WIDTH'(1)) begin
              state_next = DONE;
              secs_next  = '0;
            end else begin
              secs_next = secs_q - WIDTH'(1);
            end
          end
        end
        PAUSED: begin
          // Edges seen while paused are dropped, not queued.
          if (!bus.pause) state_next = RUN;
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.secs_left = secs_q;
  assign bus.busy      = (state == RUN) || (state == PAUSED);
  assign bus.expired   = (state == DONE);
  assign bus.tick      = tick_q;

endmodule

// File: tb/tb_vend_countdown.sv
// Directed bench for vend_countdown: a cycle-level behavioural model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_vend_countdown;
  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;

  vend_countdown_if #(.WIDTH(WIDTH)) bus ();

  vend_countdown #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "active" means a countdown is in progress, "hold" that it is frozen.
  typedef struct packed {
    logic        active;
    logic        hold;
    logic        exp;
    logic        ceq;
    logic        tick;
    logic [15:0] secs;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t cur, input logic ce, input logic st,
                                        input logic [WIDTH-1:0] lv, input logic ps,
                                        input logic cn);
    model_t n = cur;
    logic   edge_seen = ce & ~cur.ceq;
    n.tick = edge_seen;
    n.ceq  = ce;
    n.exp  = 1'b0;
    if (cn) begin
      n.active = 1'b0;
      n.hold   = 1'b0;
      n.secs   = 16'd0;
    end else if (st) begin
      n.secs   = 16'(lv);
      n.hold   = 1'b0;
      n.active = (lv != 0);
      n.exp    = (lv == 0);
    end else if (cur.active) begin
      if (cur.hold) begin
        n.hold = ps;
      end else if (ps) begin
        n.hold = 1'b1;
      end else if (edge_seen) begin
        n.secs = cur.secs - 16'd1;
        if (n.secs == 16'd0) begin
          n.active = 1'b0;
          n.exp    = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) m <= '0;
    else        m <= model_next(m, bus.c_e, bus.start, bus.load_val, bus.pause, bus.cancel);
  end

  always @(negedge clk) begin
    if (clr_n) begin
      check("model_secs",    32'(bus.secs_left), 32'(m.secs));
      check("model_busy",    32'(bus.busy),      32'(m.active));
      check("model_expired", 32'(bus.expired),   32'(m.exp));
      check("model_tick",    32'(bus.tick),      32'(m.tick));
    end
  end

  // Free-running 1 Hz stand-in: toggles every 4 clocks, so one rise per 8 clocks.
  initial begin
    bus.c_e = 1'b0;
    forever begin
      repeat (4) @(posedge clk);
      #1 bus.c_e = ~bus.c_e;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      cycle();
      if (bus.tick) break;
    end
    check(name, 32'(i < 40), 32'd1);
  endtask

  task automatic wait_secs(input string name, input int v);
    int i;
    for (i = 0; i < 400; i++) begin
      cycle();
      if (int'(bus.secs_left) == v) break;
    end
    check(name, 32'(i < 400), 32'd1);
  endtask

  task automatic wait_expired(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      cycle();
      if (bus.expired) break;
    end
    check(name, 32'(i < 400), 32'd1);
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] v);
    bus.load_val = v;
    bus.start    = 1'b1;
    cycle();
    bus.start    = 1'b0;
  endtask

  initial begin
    int seen[$];
    int n_tick;
    int n_exp;
    int n_wrap;
    int prev;
    int i;

    bus.start    = 1'b0;
    bus.load_val = '0;
    bus.pause    = 1'b0;
    bus.cancel   = 1'b0;

    // Reset state
    #2 clr_n = 1'b0;
    #1;
    check("rst_secs",    32'(bus.secs_left), 32'd0);
    check("rst_busy",    32'(bus.busy),      32'd0);
    check("rst_expired", 32'(bus.expired),   32'd0);
    check("rst_tick",    32'(bus.tick),      32'd0);
    repeat (3) cycle();
    clr_n = 1'b1;
    repeat (2) cycle();

    // Basic count of 3
    wait_tick("basic_sync");
    pulse_start(8'd3);
    check("basic_load_secs", 32'(bus.secs_left), 32'd3);
    check("basic_load_busy", 32'(bus.busy),      32'd1);
    n_exp = 0;
    for (i = 0; i < 100; i++) begin
      cycle();
      if (bus.tick) seen.push_back(int'(bus.secs_left));
      if (bus.expired) begin
        n_exp++;
        check("basic_exp_busy", 32'(bus.busy),      32'd0);
        check("basic_exp_secs", 32'(bus.secs_left), 32'd0);
        break;
      end
    end
    check("basic_expired_seen", 32'(n_exp), 32'd1);
    check("basic_tick_count", 32'(seen.size()), 32'd3);
    for (int k = 0; k < seen.size(); k++) check("basic_tick_secs", 32'(seen[k]), 32'(2 - k));
    cycle();
    check("basic_exp_one_cycle", 32'(bus.expired), 32'd0);

    // Zero load
    pulse_start(8'd0);
    check("zero_expired", 32'(bus.expired),   32'd1);
    check("zero_busy",    32'(bus.busy),      32'd0);
    check("zero_secs",    32'(bus.secs_left), 32'd0);
    cycle();
    check("zero_exp_clear", 32'(bus.expired), 32'd0);
    check("zero_busy_after", 32'(bus.busy),   32'd0);

    // Pause across three rises, resume, then pause coinciding with a rise
    wait_tick("pause_sync");
    pulse_start(8'd5);
    bus.pause = 1'b1;
    n_tick = 0;
    for (i = 0; i < 100; i++) begin
      cycle();
      if (bus.tick) n_tick++;
      if (n_tick == 3) break;
    end
    check("pause_ticks_seen", 32'(n_tick),        32'd3);
    check("pause_frozen",     32'(bus.secs_left), 32'd5);
    check("pause_busy",       32'(bus.busy),      32'd1);
    bus.pause = 1'b0;
    wait_tick("resume_tick");
    check("resume_secs", 32'(bus.secs_left), 32'd4);
    repeat (7) cycle();
    bus.pause = 1'b1;
    cycle();
    bus.pause = 1'b0;
    check("pause_rise_tick", 32'(bus.tick),      32'd1);
    check("pause_rise_secs", 32'(bus.secs_left), 32'd4);
    wait_expired("pause_expiry");
    check("pause_exp_secs", 32'(bus.secs_left), 32'd0);

    // Cancel at 2
    wait_tick("cancel_sync");
    pulse_start(8'd5);
    wait_secs("cancel_reach2", 2);
    bus.cancel = 1'b1;
    cycle();
    bus.cancel = 1'b0;
    check("cancel_secs",    32'(bus.secs_left), 32'd0);
    check("cancel_busy",    32'(bus.busy),      32'd0);
    check("cancel_expired", 32'(bus.expired),   32'd0);
    n_exp = 0;
    for (i = 0; i < 30; i++) begin
      cycle();
      if (bus.expired) n_exp++;
    end
    check("cancel_no_expiry", 32'(n_exp), 32'd0);

    // Restart while running, then start+cancel together
    wait_tick("restart_sync");
    pulse_start(8'd7);
    wait_secs("restart_reach4", 4);
    pulse_start(8'd7);
    check("restart_secs", 32'(bus.secs_left), 32'd7);
    check("restart_busy", 32'(bus.busy),      32'd1);
    bus.cancel = 1'b1;
    pulse_start(8'd9);
    bus.cancel = 1'b0;
    check("start_cancel_busy", 32'(bus.busy),      32'd0);
    check("start_cancel_secs", 32'(bus.secs_left), 32'd0);
    cycle();
    check("start_cancel_noexp", 32'(bus.expired), 32'd0);

    // Reset mid-count
    wait_tick("reset_sync");
    pulse_start(8'd6);
    wait_secs("reset_reach4", 4);
    clr_n = 1'b0;
    #1;
    check("midrst_secs",    32'(bus.secs_left), 32'd0);
    check("midrst_busy",    32'(bus.busy),      32'd0);
    check("midrst_expired", 32'(bus.expired),   32'd0);
    check("midrst_tick",    32'(bus.tick),      32'd0);
    repeat (3) cycle();
    clr_n = 1'b1;
    n_exp  = 0;
    n_tick = 0;
    for (i = 0; i < 40; i++) begin
      cycle();
      if (bus.expired) n_exp++;
      if (bus.tick) n_tick++;
    end
    check("midrst_no_expiry", 32'(n_exp), 32'd0);
    check("midrst_ticks",     32'(n_tick >= 4), 32'd1);

    // Maximum load
    wait_tick("max_sync");
    pulse_start(8'd255);
    check("max_load_secs", 32'(bus.secs_left), 32'd255);
    n_tick = 0;
    n_exp  = 0;
    n_wrap = 0;
    prev   = 255;
    for (i = 0; i < 2200; i++) begin
      cycle();
      if (bus.tick) n_tick++;
      if (int'(bus.secs_left) > prev) n_wrap++;
      prev = int'(bus.secs_left);
      if (bus.expired) begin
        n_exp++;
        break;
      end
    end
    check("max_ticks_to_expiry", 32'(n_tick), 32'd255);
    check("max_one_expiry",      32'(n_exp),  32'd1);
    check("max_no_wrap",         32'(n_wrap), 32'd0);
    n_exp = 0;
    for (i = 0; i < 30; i++) begin
      cycle();
      if (bus.expired) n_exp++;
      if (bus.secs_left != 0) n_wrap++;
    end
    check("max_no_second_expiry", 32'(n_exp),  32'd0);
    check("max_stays_zero",       32'(n_wrap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_countdown.md
# vend_countdown

Seconds-resolution countdown timer for the vending machine's transaction timeout (coin-insert and selection windows). It takes the toggling 1 Hz square wave `c_e` from the clock-enable divider and turns each rising edge into a one-cycle tick. It counts a loaded number of seconds down to zero and reports expiry to the main vending FSM. It supports start/restart, pause and cancel.

## Interface
- `WIDTH`, 8: width of the seconds counter and load value.
- `clk` in 1: system clock (100 MHz); all logic on rising edge.
- `clr_n` in 1: asynchronous, active-low reset.
- `c_e` in 1: 1 Hz square wave from the divider, synchronous to `clk`; each rising edge marks one second.
- `start` in 1: one-cycle pulse; loads `load_val` and begins counting.
- `load_val` in WIDTH: seconds to count; sampled only in the cycle `start` is high.
- `pause` in 1: level; while high the countdown holds.
- `cancel` in 1: one-cycle pulse; aborts without expiry.
- `secs_left` out WIDTH: remaining seconds, registered.
- `busy` out 1: high in RUN or PAUSED.
- `expired` out 1: one-cycle pulse when the count reaches zero.
- `tick` out 1: registered one-cycle pulse per `c_e` rising edge, free-running in all states.

## Operation
- Edge detect:
  - `c_e_q` is a register of `c_e`.
  - `rise = c_e & ~c_e_q` is combinational.
  - `tick <= rise`.
- States:
  - IDLE: reset state.
  - RUN: counting.
  - PAUSED: holding.
  - DONE: transient, one cycle.
- Input priority each cycle: `cancel` > `start` > `pause` > `rise`.
- IDLE:
  - `start` with `load_val` ≠ 0 → RUN, `secs_left <= load_val`.
  - `start` with `load_val` = 0 → DONE, `secs_left <= 0`.
  - `pause` alone is ignored.
  - `cancel` leaves the state at IDLE.
- RUN:
  - `pause` → PAUSED, no decrement that cycle, even if `rise`.
  - Otherwise, on `rise`: if `secs_left` = 1 → DONE with `secs_left <= 0`; else `secs_left <= secs_left - 1`.
- PAUSED:
  - `pause` low → RUN.
  - `rise` is ignored; edges occurring while paused are lost, not queued.
- DONE: unconditionally → IDLE next cycle, unless `cancel` or `start` is present, which are handled as in RUN.
- `start` in RUN/PAUSED/DONE restarts:
  - reloads `load_val`;
  - goes to RUN, or to DONE if `load_val` = 0;
  - goes to RUN even if `pause` is high, and pauses on the following cycle if `pause` is still high.
- `cancel` in any state → IDLE with `secs_left <= 0`; `expired` is not asserted.
- `expired = (state == DONE)` (Moore); exactly one cycle per expiry.
- `busy = (state == RUN) | (state == PAUSED)`.
- Arithmetic:
  - unsigned WIDTH bits;
  - the decrement never wraps, because a count of 1 always transitions to DONE;
  - `load_val` max is 2^WIDTH−1.
- First second is partial: the first decrement occurs at the first `rise` after entering RUN, 0 to 1 s later. This is accepted behaviour.

## Timing
- Reset (`clr_n` low, asynchronous): state = IDLE, `secs_left` = 0, `busy` = 0, `expired` = 0, `tick` = 0, `c_e_q` = 0.
- Reset asserted mid-count returns all outputs to reset values immediately.
  - After release: IDLE, no expiry is generated.
  - A spurious `rise` in the first cycle after release (c_e high) only produces `tick`; it is harmless in IDLE.
- `start` at cycle N → `busy` = 1 and `secs_left` = `load_val` at N+1.
- `rise` at cycle N (c_e high, c_e_q low) → `tick` and the decremented `secs_left` visible at N+1.
- Final decrement at N → `secs_left` = 0 and `expired` = 1 at N+1; IDLE with `expired` = 0 at N+2.
- `start` with `load_val` = 0 at N → `expired` = 1 at N+1.
- `pause` high at N → PAUSED at N+1; `pause` low at M → RUN at M+1.
- Outputs depend only on registers; there are no combinational input-to-output paths.

## Test plan
For simulation, drive `c_e` toggling every 4 clocks, so a `rise` occurs every 8 clocks.
- Basic count: `start` with `load_val` = 3 → `secs_left` goes 3, 2, 1, 0 on successive `rise`+1 cycles; a single-cycle `expired` coincides with `secs_left` = 0; `busy` drops on the same cycle.
- Zero load: `start` with `load_val` = 0 → `expired` = 1 on the next cycle, `busy` never high.
- Pause:
  - load 5, hold `pause` high across 3 rises → `secs_left` is frozen;
  - release → countdown resumes from the frozen value;
  - `pause` and `rise` in the same cycle → no decrement.
- Cancel/restart:
  - `cancel` at `secs_left` = 2 → IDLE, `secs_left` = 0, no `expired`;
  - `start` with 7 while RUN at 4 → `secs_left` = 7;
  - `start` and `cancel` in the same cycle → cancel wins.
- Reset mid-count: `clr_n` low at `secs_left` = 4 → all outputs 0 immediately; after release no `expired` occurs and `tick` continues to pulse.
- Max load: `start` with 255 → after 255 rises exactly one `expired`; `secs_left` never wraps to 255.
